// File: rtl/store_sequencer.sv
// Board front-end for the 4x8 memory: debounces the store/next buttons and issues one store strobe per press.
// Build option: define STORE_SEQ_AUTO_ADVANCE_EN to step addr after every store.
module store_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sw,
  input  logic       btn_store,
  input  logic       btn_next,
  output logic [7:0] data,
  output logic       store,
  output logic [1:0] addr,
  output logic       busy
);

  localparam int BTN_STORE = 0;
  localparam int BTN_NEXT  = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    STROBE,
    ADVANCE,
    RELEASE
  } state_t;

  state_t               state;
  logic [1:0]           raw;
  logic [1:0]           sync_a;
  logic [1:0]           sync_b;
  logic [1:0]           stable;
  logic [1:0]           press;
  logic [CNT_WIDTH-1:0] cnt [2];

  assign raw = {btn_next, btn_store};

  // Two-flop synchronisers feeding one debounce counter per button. A press is
  // flagged on the same edge the stable level rises, so it is already registered.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
      stable <= '0;
      press  <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync_b[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync_b[i];
          press[i]  <= sync_b[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Data is captured on the transition into LATCH so it is settled a full cycle
  // before the strobe; addr only moves once the strobe cycle has ended.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      data  <= 8'h00;
      store <= 1'b0;
      addr  <= 2'd0;
      busy  <= 1'b0;
    end else begin
      store <= 1'b0;
      case (state)
        IDLE: begin
          if (press[BTN_STORE]) begin
            state <= LATCH;
            data  <= sw;
            busy  <= 1'b1;
          end else if (press[BTN_NEXT]) begin
            addr <= addr + 2'd1;
          end
        end
        LATCH: begin
          state <= STROBE;
          store <= 1'b1;
        end
        STROBE: state <= ADVANCE;
        ADVANCE: begin
`ifdef STORE_SEQ_AUTO_ADVANCE_EN
          addr <= addr + 2'd1;
`else
          addr <= addr;
`endif
          state <= RELEASE;
        end
        RELEASE: begin
          if (!stable[BTN_STORE]) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/store_sequencer.md
Name: store_sequencer

Overview:
- Front-end stage that sits directly upstream of the 4x8 memory system and drives its data, store and addr inputs.
- Converts raw board inputs (8 data switches, a store button, a next-address button) into clean handshake signals.
- Buttons are synchronised and debounced.
- Each qualified store press produces exactly one single-cycle store strobe, with data captured and addr held stable.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive synchronised-input cycles a new level must hold before it is accepted (10 ms at 100 MHz)
CNT_WIDTH, 20, debounce counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock; sole clock domain
reset  input  1  synchronous, active-high reset
sw  input  8  raw data switches
btn_store  input  1  raw store button, asynchronous, bouncy
btn_next  input  1  raw next-address button, asynchronous, bouncy
data  output  8  registered data to memory system
store  output  1  one-cycle store strobe to memory system
addr  output  2  registered byte address to memory system
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: data=0x00, store=0, addr=0, busy=0, FSM=IDLE, debounced levels=0, counters=0, sync flops=0.
- Input sync: each button passes through 2 flops.
- Debounce, per button:
  - Counter clears whenever the synced level equals the stable level.
  - Otherwise it increments; on the cycle it equals DEBOUNCE_CYCLES-1 with mismatch still present, the stable level takes the synced level and the counter clears.
  - A raw level held from edge k changes the stable level at edge k+2+DEBOUNCE_CYCLES.
  - Any mismatch gap restarts the count.
- Edge detect: a press is the registered rising edge of the stable level, one cycle wide. Falling edges are not events.
- FSM states:
  - IDLE: store press -> LATCH. Else next press -> addr<=addr+1 (mod 4), stay IDLE.
  - LATCH: data<=sw. -> STROBE.
  - STROBE: store=1 for exactly this cycle; data and addr unchanged. -> ADVANCE.
  - ADVANCE: address update per optional feature. -> RELEASE.
  - RELEASE: wait until stable store level = 0. -> IDLE.
- Outputs: store is a registered decode of STROBE, so data and addr are stable the full cycle before, during and after the strobe. busy = (state != IDLE).
- Address arithmetic: 2-bit wrap, 3+1 -> 0. No saturation.
- Simultaneous store and next press in IDLE: store wins; next is discarded, not queued.
- Next press while not IDLE: ignored.
- sw changes after LATCH: no effect on data until the next store sequence.
- Reset mid-operation (any state): all state returns to reset values at that edge; store is 0 from that edge on.
  - A button still physically held after reset release is seen as a fresh press once debounced, since stable resets to 0.
- Store latency: press event at edge n -> LATCH at n+1, store high during cycle n+2.

Optional Feature:
Macro STORE_SEQ_AUTO_ADVANCE_EN.
- Defined: ADVANCE sets addr<=addr+1 (mod 4), so successive stores fill bytes 0,1,2,3,0...
- Not defined: ADVANCE leaves addr unchanged, and addr moves only via btn_next. FSM state sequence and timing are identical in both builds.

Test Plan (DEBOUNCE_CYCLES=4, CNT_WIDTH=3):
1. Reset held 2 cycles with buttons high, sw=0xFF -> data=0x00, store=0, addr=0, busy=0.
2. sw=0xA5; btn_store clean high for 20 cycles -> exactly one store pulse, 1 cycle wide, with data=0xA5 and addr=0 during it. Afterwards addr=1 with macro, 0 without. busy stays high until the debounced release.
3. btn_store toggles every 2 cycles for 12 cycles, then steady high for 20 -> exactly one store pulse. Zero pulses during the bounce window.
4. Four clean store presses, with macro, sw=0x11,0x22,0x33,0x44 -> pulses carry addr 0,1,2,3 with matching data; final addr=0.
5. addr=3, IDLE, clean btn_next press -> addr=0, store never asserts, data unchanged. Next press and store press debounced on the same edge -> one store pulse, and addr changes only per ADVANCE.
6. Reset asserted during STROBE with btn_store held -> store=0 and addr=0 after that edge. After reset release, exactly one new pulse appears 2+4 cycles plus 3 FSM cycles later.
